// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding data-memory access with wait timeout.
// Define LSU_ALIGN_CHECK_EN to reject misaligned or out-of-window addresses.
module load_store_unit #(
  parameter int unsigned BASE_ADDR      = 1024,
  parameter int unsigned DEPTH_WORDS    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        freeze,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] load_data,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic [31:0] address,
  output logic [31:0] dataIn,
  input  logic [31:0] dataOut,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [3:0] TO_LIM = 4'(TIMEOUT_CYCLES);

  state_e      state_q;
  logic        op_wr_q;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] ld_q;
  logic        r_en_q;
  logic        w_en_q;
  logic        valid_q;
  logic        err_q;
  logic        bad_addr;
  logic        any_req;
  logic        both_req;

`ifdef LSU_ALIGN_CHECK_EN
  localparam logic [31:0] LO_ADDR = 32'(BASE_ADDR);
  localparam logic [31:0] HI_ADDR =
    32'(BASE_ADDR + 4 * DEPTH_WORDS - 1);

  assign bad_addr = (req_addr[1:0] != 2'b00)
                 || (req_addr < LO_ADDR)
                 || (req_addr > HI_ADDR);
`else
  assign bad_addr = 1'b0;
`endif

  assign any_req  = req_rd | req_wr;
  assign both_req = req_rd & req_wr;

  // Saturating wait counter; never wraps back to zero.
  assign cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      op_wr_q <= 1'b0;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      ld_q    <= 32'd0;
      r_en_q  <= 1'b0;
      w_en_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (both_req || (any_req && bad_addr)) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            err_q   <= 1'b1;
          end else if (any_req) begin
            state_q <= ACCESS;
            op_wr_q <= req_wr;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= 4'd0;
            r_en_q  <= req_rd;
            w_en_q  <= req_wr;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            if (!op_wr_q) begin
              ld_q <= dataOut;
            end
            state_q <= DONE;
            valid_q <= 1'b1;
            err_q   <= 1'b0;
            r_en_q  <= 1'b0;
            w_en_q  <= 1'b0;
          end else if (cnt_q == TO_LIM) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            err_q   <= 1'b1;
            r_en_q  <= 1'b0;
            w_en_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          r_en_q  <= 1'b0;
          w_en_q  <= 1'b0;
        end
      endcase
    end
  end

  assign freeze = (state_q == ACCESS)
               || ((state_q == IDLE) && any_req);

  assign resp_valid = valid_q;
  assign resp_err   = err_q;
  assign load_data  = ld_q;
  assign mem_r_en   = r_en_q;
  assign mem_w_en   = w_en_q;
  assign address    = addr_q;
  assign dataIn     = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a response scoreboard.
// Build with +define+LSU_ALIGN_CHECK_EN to exercise address checking.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_rd;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        freeze;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] load_data;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        mem_ready;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t        sbq[$];
  int          nchk = 0;
  int          nerr = 0;
  logic [31:0] exp_ld;
  int          ncyc;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_rd     (req_rd),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .freeze     (freeze),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .load_data  (load_data),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .address    (address),
    .dataIn     (dataIn),
    .dataOut    (dataOut),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic err, input logic [31:0] data);
    rsp_t r;
    r.err  = err;
    r.data = data;
    sbq.push_back(r);
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      chk("rsp_expected", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        rsp_t r;
        r = sbq.pop_front();
        chk("rsp_err", 32'(resp_err), 32'(r.err));
        chk("rsp_load_data", load_data, r.data);
      end
      chk("rsp_no_enables", {30'd0, mem_r_en, mem_w_en}, 32'd0);
      chk("rsp_no_freeze", 32'(freeze), 32'd0);
    end
    chk("en_exclusive", 32'(mem_r_en & mem_w_en), 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    req_rd    = 1'b0;
    req_wr    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    dataOut   = 32'd0;
    mem_ready = 1'b0;
    exp_ld    = 32'd0;
    repeat (3) tick();

    // Reset state
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_dataIn", dataIn, 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_enables", {30'd0, mem_r_en, mem_w_en}, 32'd0);
    chk("rst_freeze", 32'(freeze), 32'd0);
    rst = 1'b1;
    tick();

    // Store, memory ready at once
    req_wr    = 1'b1;
    req_addr  = 32'd1028;
    req_wdata = 32'hDEADBEEF;
    mem_ready = 1'b1;
    #1;
    chk("st_freeze_idle", 32'(freeze), 32'd1);
    push(1'b0, exp_ld);
    tick();
    req_wr = 1'b0;
    req_wdata = 32'h0;
    chk("st_w_en", 32'(mem_w_en), 32'd1);
    chk("st_r_en", 32'(mem_r_en), 32'd0);
    chk("st_address", address, 32'd1028);
    chk("st_dataIn", dataIn, 32'hDEADBEEF);
    chk("st_freeze", 32'(freeze), 32'd1);
    tick();
    chk("st_valid", 32'(resp_valid), 32'd1);
    chk("st_w_en_off", 32'(mem_w_en), 32'd0);
    tick();
    chk("st_valid_pulse", 32'(resp_valid), 32'd0);

    // Load with three wait cycles
    mem_ready = 1'b0;
    dataOut   = 32'hDEADBEEF;
    req_rd    = 1'b1;
    req_addr  = 32'd1028;
    exp_ld    = 32'hDEADBEEF;
    push(1'b0, exp_ld);
    tick();
    req_rd = 1'b0;
    ncyc = 0;
    for (int i = 0; i < 3; i++) begin
      if (freeze && mem_r_en) ncyc++;
      chk("ld_address", address, 32'd1028);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    if (freeze && mem_r_en) ncyc++;
    tick();
    mem_ready = 1'b0;
    chk("ld_freeze_cycles", ncyc, 32'd4);
    chk("ld_valid", 32'(resp_valid), 32'd1);
    chk("ld_data", load_data, 32'hDEADBEEF);
    tick();

    // Load that never completes: timeout
    dataOut  = 32'h12345678;
    req_rd   = 1'b1;
    req_addr = 32'd1032;
    push(1'b1, exp_ld);
    tick();
    req_rd = 1'b0;
    ncyc = 0;
    for (int i = 0; i < 40 && !resp_valid; i++) begin
      if (mem_r_en) ncyc++;
      tick();
    end
    chk("to_access_cycles", ncyc, 32'd16);
    chk("to_valid", 32'(resp_valid), 32'd1);
    chk("to_err", 32'(resp_err), 32'd1);
    chk("to_load_data", load_data, 32'hDEADBEEF);
    tick();

    // Both request lines high
    req_rd   = 1'b1;
    req_wr   = 1'b1;
    req_addr = 32'd1028;
    push(1'b1, exp_ld);
    tick();
    req_rd = 1'b0;
    req_wr = 1'b0;
    chk("both_valid", 32'(resp_valid), 32'd1);
    chk("both_err", 32'(resp_err), 32'd1);
    chk("both_enables", {30'd0, mem_r_en, mem_w_en}, 32'd0);
    tick();
    chk("both_pulse", 32'(resp_valid), 32'd0);

    // Reset during an access wait
    req_rd   = 1'b1;
    req_addr = 32'd1036;
    tick();
    req_rd = 1'b0;
    chk("rw_r_en", 32'(mem_r_en), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_ld = 32'd0;
    chk("rw_enables", {30'd0, mem_r_en, mem_w_en}, 32'd0);
    chk("rw_valid", 32'(resp_valid), 32'd0);
    chk("rw_load_data", load_data, 32'd0);
    chk("rw_address", address, 32'd0);
    repeat (2) tick();
    chk("rw_no_valid", 32'(resp_valid), 32'd0);
    req_wr    = 1'b1;
    req_addr  = 32'd1040;
    req_wdata = 32'hCAFEF00D;
    mem_ready = 1'b1;
    push(1'b0, exp_ld);
    tick();
    req_wr = 1'b0;
    chk("rw_st_w_en", 32'(mem_w_en), 32'd1);
    chk("rw_st_dataIn", dataIn, 32'hCAFEF00D);
    tick();
    chk("rw_st_valid", 32'(resp_valid), 32'd1);
    tick();

    // Misaligned and out-of-window loads
    for (int k = 0; k < 2; k++) begin
      req_rd   = 1'b1;
      req_addr = (k == 0) ? 32'd1026 : 32'd1088;
      dataOut  = (k == 0) ? 32'h0BADF00D : 32'h11112222;
`ifdef LSU_ALIGN_CHECK_EN
      push(1'b1, exp_ld);
      tick();
      req_rd = 1'b0;
      chk("ac_valid", 32'(resp_valid), 32'd1);
      chk("ac_err", 32'(resp_err), 32'd1);
      chk("ac_enables", {30'd0, mem_r_en, mem_w_en}, 32'd0);
`else
      exp_ld = dataOut;
      push(1'b0, exp_ld);
      tick();
      req_rd = 1'b0;
      chk("ac_r_en", 32'(mem_r_en), 32'd1);
      chk("ac_address", address, req_addr);
      tick();
      chk("ac_valid", 32'(resp_valid), 32'd1);
      chk("ac_data", load_data, exp_ld);
`endif
      tick();
    end

    repeat (3) tick();
    chk("sb_empty", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
